// File: rtl/display_pkg.sv
// Shared types and constants for the display frame scheduler.
// Source IDs double as bit positions in the arbiter's one-hot winner vector.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam int DEF_NUM_DIGITS = 6;
    localparam int DEF_SEG_BITS   = 8;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/display_frame_scheduler_if.sv
// Source/display-chain bundle for display_frame_scheduler; master = scheduler side.
// The blink input exists only when DISPLAY_BLINK_EN is defined.
interface display_frame_scheduler_if #(
    parameter int NUM_DIGITS = 6,
    parameter int SEG_BITS   = 8
);
    localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                req_a;
    logic                req_b;
    logic                gnt_a;
    logic                gnt_b;
    logic [SEL_W-1:0]    digit_sel;
    logic [SEG_BITS-1:0] seg_a;
    logic [SEG_BITS-1:0] seg_b;
    logic                sr_data;
    logic                sr_clk;
    logic                sr_latch;
    logic                busy;
    logic                frame_done;
`ifdef DISPLAY_BLINK_EN
    logic                blink;

    modport master (
        input  req_a, req_b, seg_a, seg_b, blink,
        output gnt_a, gnt_b, digit_sel, sr_data, sr_clk, sr_latch, busy, frame_done
    );
    modport slave (
        output req_a, req_b, seg_a, seg_b, blink,
        input  gnt_a, gnt_b, digit_sel, sr_data, sr_clk, sr_latch, busy, frame_done
    );
`else
    modport master (
        input  req_a, req_b, seg_a, seg_b,
        output gnt_a, gnt_b, digit_sel, sr_data, sr_clk, sr_latch, busy, frame_done
    );
    modport slave (
        output req_a, req_b, seg_a, seg_b,
        input  gnt_a, gnt_b, digit_sel, sr_data, sr_clk, sr_latch, busy, frame_done
    );
`endif

endinterface

// File: rtl/display_frame_scheduler_arbiter.sv
// Two-requester round-robin arbiter: on a tie the source not granted last wins.
// Purely combinational; the caller owns the last-granted register.
module rr_arbiter2
    import display_pkg::*;
(
    input  logic       req_a,
    input  logic       req_b,
    input  logic       last_granted,
    output logic [1:0] win
);

    always_comb begin
        win = 2'b00;
        if (req_a && req_b) begin
            if (last_granted == SRC_B) begin
                win[SRC_A] = 1'b1;
            end else begin
                win[SRC_B] = 1'b1;
            end
        end else if (req_a) begin
            win[SRC_A] = 1'b1;
        end else if (req_b) begin
            win[SRC_B] = 1'b1;
        end
    end

endmodule

// File: rtl/display_frame_scheduler.sv
// Frame sequencer for the serial 7-segment chain, shared by sources A and B.
// Optional DISPLAY_BLINK_EN adds a blink input and a frame-counted blink phase.
module display_frame_scheduler
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int SEG_BITS   = DEF_SEG_BITS
`ifdef DISPLAY_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 16
`endif
) (
    input logic                       clk,
    input logic                       rst_n,
    input logic                       en,
    display_frame_scheduler_if.master bus
);

    localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PH_W  = $clog2(2 * SEG_BITS);
    localparam logic [SEL_W-1:0] LAST_DIGIT = SEL_W'(NUM_DIGITS - 1);
    localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(2 * SEG_BITS - 1);

    state_t              state_reg, state_next;
    logic                gnt_a_reg, gnt_a_next;
    logic                gnt_b_reg, gnt_b_next;
    logic                busy_reg, busy_next;
    logic [SEL_W-1:0]    digit_sel_reg, digit_sel_next;
    logic [PH_W-1:0]     phase_reg, phase_next;
    logic [SEG_BITS-1:0] sreg_reg, sreg_next;
    logic                sr_data_reg, sr_data_next;
    logic                sr_clk_reg, sr_clk_next;
    logic                sr_latch_reg, sr_latch_next;
    logic                frame_done_reg, frame_done_next;
    logic                last_granted_reg, last_granted_next;

    logic [1:0]          win;
    logic [SEG_BITS-1:0] src_byte;
    logic [SEG_BITS-1:0] load_byte;

    rr_arbiter2 u_arbiter (
        .req_a        (bus.req_a),
        .req_b        (bus.req_b),
        .last_granted (last_granted_reg),
        .win          (win)
    );

    assign src_byte = gnt_b_reg ? bus.seg_b : bus.seg_a;

`ifdef DISPLAY_BLINK_EN
    localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BC_W-1:0] BLINK_WRAP = BC_W'(BLINK_FRAMES - 1);

    logic [BC_W-1:0] blink_cnt_reg, blink_cnt_next;
    logic            blink_on_reg, blink_on_next;

    assign load_byte = (bus.blink && !blink_on_reg) ? '0 : src_byte;

    // Advances once per frame_done, regardless of which source owned the frame.
    always_comb begin
        blink_cnt_next = blink_cnt_reg;
        blink_on_next  = blink_on_reg;
        if (en && state_reg == LATCH) begin
            if (blink_cnt_reg == BLINK_WRAP) begin
                blink_cnt_next = '0;
                blink_on_next  = !blink_on_reg;
            end else begin
                blink_cnt_next = blink_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_reg <= '0;
            blink_on_reg  <= 1'b1;
        end else begin
            blink_cnt_reg <= blink_cnt_next;
            blink_on_reg  <= blink_on_next;
        end
    end
`else
    assign load_byte = src_byte;
`endif

    // All outputs are registered: each branch computes what the next cycle shows.
    always_comb begin
        state_next        = state_reg;
        gnt_a_next        = gnt_a_reg;
        gnt_b_next        = gnt_b_reg;
        busy_next         = busy_reg;
        digit_sel_next    = digit_sel_reg;
        phase_next        = phase_reg;
        sreg_next         = sreg_reg;
        sr_data_next      = sr_data_reg;
        sr_clk_next       = sr_clk_reg;
        sr_latch_next     = sr_latch_reg;
        frame_done_next   = frame_done_reg;
        last_granted_next = last_granted_reg;

        if (en) begin
            case (state_reg)
                IDLE: begin
                    if (win != 2'b00) begin
                        gnt_a_next     = win[SRC_A];
                        gnt_b_next     = win[SRC_B];
                        busy_next      = 1'b1;
                        digit_sel_next = LAST_DIGIT;
                        state_next     = LOAD;
                    end
                end
                LOAD: begin
                    sreg_next    = load_byte;
                    phase_next   = '0;
                    sr_data_next = load_byte[SEG_BITS-1];
                    sr_clk_next  = 1'b0;
                    state_next   = SHIFT;
                end
                SHIFT: begin
                    phase_next = phase_reg + 1'b1;
                    if (!phase_reg[0]) begin
                        sr_clk_next = 1'b1;
                    end else begin
                        sr_clk_next  = 1'b0;
                        sreg_next    = {sreg_reg[SEG_BITS-2:0], 1'b0};
                        sr_data_next = sreg_reg[SEG_BITS-2];
                        if (phase_reg == LAST_PHASE) begin
                            sr_data_next = 1'b0;
                            if (digit_sel_reg == '0) begin
                                sr_latch_next   = 1'b1;
                                frame_done_next = 1'b1;
                                state_next      = LATCH;
                            end else begin
                                digit_sel_next = digit_sel_reg - 1'b1;
                                state_next     = LOAD;
                            end
                        end
                    end
                end
                LATCH: begin
                    sr_latch_next     = 1'b0;
                    frame_done_next   = 1'b0;
                    gnt_a_next        = 1'b0;
                    gnt_b_next        = 1'b0;
                    busy_next         = 1'b0;
                    last_granted_next = gnt_b_reg ? SRC_B : SRC_A;
                    state_next        = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            gnt_a_reg        <= 1'b0;
            gnt_b_reg        <= 1'b0;
            busy_reg         <= 1'b0;
            digit_sel_reg    <= '0;
            phase_reg        <= '0;
            sreg_reg         <= '0;
            sr_data_reg      <= 1'b0;
            sr_clk_reg       <= 1'b0;
            sr_latch_reg     <= 1'b0;
            frame_done_reg   <= 1'b0;
            last_granted_reg <= SRC_B;
        end else begin
            state_reg        <= state_next;
            gnt_a_reg        <= gnt_a_next;
            gnt_b_reg        <= gnt_b_next;
            busy_reg         <= busy_next;
            digit_sel_reg    <= digit_sel_next;
            phase_reg        <= phase_next;
            sreg_reg         <= sreg_next;
            sr_data_reg      <= sr_data_next;
            sr_clk_reg       <= sr_clk_next;
            sr_latch_reg     <= sr_latch_next;
            frame_done_reg   <= frame_done_next;
            last_granted_reg <= last_granted_next;
        end
    end

    assign bus.gnt_a      = gnt_a_reg;
    assign bus.gnt_b      = gnt_b_reg;
    assign bus.busy       = busy_reg;
    assign bus.digit_sel  = digit_sel_reg;
    assign bus.sr_data    = sr_data_reg;
    assign bus.sr_clk     = sr_clk_reg;
    assign bus.sr_latch   = sr_latch_reg;
    assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_display_frame_scheduler.sv
// Directed bench for display_frame_scheduler (default build, 6 digits x 8 bits).
// Expected serial bits and frame owners are queued at stimulus time and popped by a monitor.
module tb_display_frame_scheduler;

    logic clk;
    logic rst_n;
    logic en;

    int checks = 0;
    int errors = 0;

    logic       bit_q[$];
    logic [1:0] frame_q[$];
    logic       prev_sr_clk   = 1'b0;
    logic       prev_sr_latch = 1'b0;

    localparam logic [1:0] OWN_A = 2'b01;
    localparam logic [1:0] OWN_B = 2'b10;

    display_frame_scheduler_if #(.NUM_DIGITS(6), .SEG_BITS(8)) bus ();

    display_frame_scheduler #(.NUM_DIGITS(6), .SEG_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus)
    );

    assign bus.seg_a = 8'h80 | {5'b0, bus.digit_sel};
    assign bus.seg_b = 8'h5A ^ {5'b0, bus.digit_sel};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] seg_model(input logic [1:0] owner, input int d);
        if (owner == OWN_A) return 8'h80 | 8'(d);
        return 8'h5A ^ 8'(d);
    endfunction

    task automatic push_frame(input logic [1:0] owner);
        logic [7:0] b;
        for (int d = 5; d >= 0; d--) begin
            b = seg_model(owner, d);
            for (int k = 7; k >= 0; k--) bit_q.push_back(b[k]);
        end
        frame_q.push_back(owner);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called in a grant-high cycle numbered 'start'; returns the cycle number of frame_done.
    task automatic wait_done(input int start, output int cyc);
        cyc = start;
        while (bus.frame_done !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
    endtask

    // Scoreboard monitor: one serial bit per rising sr_clk, one owner per rising sr_latch.
    always @(negedge clk) begin
        logic       exp_bit;
        logic [1:0] exp_own;
        if (bus.sr_clk === 1'b1 && prev_sr_clk === 1'b0) begin
            exp_bit = (bit_q.size() != 0) ? bit_q.pop_front() : 1'bx;
            checks++;
            assert (bus.sr_data === exp_bit) else begin
                errors++;
                $error("FAIL sr_bit: observed=%b expected=%b", bus.sr_data, exp_bit);
            end
            $display("bit sr_data=%b expected=%b", bus.sr_data, exp_bit);
        end
        if (bus.sr_latch === 1'b1 && prev_sr_latch === 1'b0) begin
            exp_own = (frame_q.size() != 0) ? frame_q.pop_front() : 2'bxx;
            checks++;
            assert ({bus.gnt_b, bus.gnt_a} === exp_own) else begin
                errors++;
                $error("FAIL frame_owner: observed=%b expected=%b", {bus.gnt_b, bus.gnt_a}, exp_own);
            end
            $display("frame latched owner=%b expected=%b", {bus.gnt_b, bus.gnt_a}, exp_own);
        end
        prev_sr_clk   = bus.sr_clk;
        prev_sr_latch = bus.sr_latch;
    end

    initial begin
        int cyc;
        rst_n     = 1'b0;
        en        = 1'b1;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_gnt",    {30'b0, bus.gnt_b, bus.gnt_a}, 0);
        chk("rst_busy",   bus.busy, 0);
        chk("rst_sel",    bus.digit_sel, 0);
        chk("rst_sr",     {29'b0, bus.sr_data, bus.sr_clk, bus.sr_latch}, 0);
        chk("rst_done",   bus.frame_done, 0);
        rst_n = 1'b1;

        // Tie: frames alternate A, B, A, B starting with A
        bus.req_a = 1'b1;
        bus.req_b = 1'b1;
        push_frame(OWN_A); push_frame(OWN_B); push_frame(OWN_A); push_frame(OWN_B);
        for (int f = 0; f < 4; f++) begin
            tick();
            chk("tie_gnt", {30'b0, bus.gnt_b, bus.gnt_a}, (f % 2 == 1) ? 32'(OWN_B) : 32'(OWN_A));
            wait_done(1, cyc);
            chk("tie_len", cyc, 103);
            if (f == 3) begin
                bus.req_a = 1'b0;
                bus.req_b = 1'b0;
            end
            tick();
            chk("tie_idle_busy", bus.busy, 0);
        end

        // Single source A: latency, length, latch, release
        bus.req_a = 1'b1;
        push_frame(OWN_A);
        tick();
        chk("a_gnt",  {30'b0, bus.gnt_b, bus.gnt_a}, 32'(OWN_A));
        chk("a_busy", bus.busy, 1);
        chk("a_sel_first", bus.digit_sel, 5);
        bus.req_a = 1'b0;
        wait_done(1, cyc);
        chk("a_len", cyc, 103);
        chk("a_latch", bus.sr_latch, 1);
        chk("a_sel_last", bus.digit_sel, 0);
        tick();
        chk("a_drop_gnt",  {30'b0, bus.gnt_b, bus.gnt_a}, 0);
        chk("a_drop_busy", bus.busy, 0);
        chk("a_drop_done", bus.frame_done, 0);

        // Request dropped mid-frame does not shorten it
        bus.req_b = 1'b1;
        push_frame(OWN_B);
        tick();
        chk("drop_gnt", {30'b0, bus.gnt_b, bus.gnt_a}, 32'(OWN_B));
        cyc = 1;
        repeat (9) begin
            tick();
            cyc++;
        end
        bus.req_b = 1'b0;
        wait_done(cyc, cyc);
        chk("drop_len", cyc, 103);
        tick();

        // en low for 7 cycles while sr_clk is high
        bus.req_a = 1'b1;
        push_frame(OWN_A);
        tick();
        bus.req_a = 1'b0;
        cyc = 1;
        while (!(bus.sr_clk === 1'b1 && cyc >= 40) && cyc < 200) begin
            tick();
            cyc++;
        end
        en = 1'b0;
        repeat (7) tick();
        chk("en_sr_clk_held", bus.sr_clk, 1);
        chk("en_busy_held",   bus.busy, 1);
        en = 1'b1;
        cyc += 7;
        wait_done(cyc, cyc);
        chk("en_len", cyc, 110);
        tick();

        // Async reset at cycle 50 aborts the frame; request held restarts it
        bus.req_a = 1'b1;
        push_frame(OWN_A);
        tick();
        cyc = 1;
        while (cyc < 50) begin
            tick();
            cyc++;
        end
        #3 rst_n = 1'b0;
        #1;
        chk("arst_gnt",  {30'b0, bus.gnt_b, bus.gnt_a}, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_sr",   {29'b0, bus.sr_data, bus.sr_clk, bus.sr_latch}, 0);
        chk("arst_done", bus.frame_done, 0);
        bit_q.delete();
        frame_q.delete();
        push_frame(OWN_A);
        #2 rst_n = 1'b1;
        tick();
        chk("arst_regnt", {30'b0, bus.gnt_b, bus.gnt_a}, 32'(OWN_A));
        bus.req_a = 1'b0;
        wait_done(1, cyc);
        chk("arst_len", cyc, 103);
        tick();

        chk("sb_bits_left",   bit_q.size(), 0);
        chk("sb_frames_left", frame_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_frame_scheduler.md
# display_frame_scheduler

Sequences the serial 7-segment shift-register chain one frame at a time and shares it between two digit sources: A (time display) and B (set/alarm display). Each frame loads NUM_DIGITS parallel segment bytes from the granted source, shifts them out serially and latches the external registers. It sits between the clock/config datapaths and the external display chain, replacing free-running shift control with a request/grant handshake.

## Interface
- NUM_DIGITS, 6: digits per frame (2..8).
- SEG_BITS, 8: bits per digit (segments plus decimal point).
- BLINK_FRAMES, 16: frames per blink half-period (only with the macro).

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  advance enable; low freezes all state and outputs.
- req_a, req_b  in  1  level frame requests from sources A and B.
- gnt_a, gnt_b  out  1  grant; one-hot or zero, held for the whole frame.
- digit_sel  out  $clog2(NUM_DIGITS)  digit index being fetched.
- seg_a, seg_b  in  SEG_BITS  segment byte for digit_sel from each source.
- sr_data  out  1  serial data, MSB first.
- sr_clk  out  1  external shift clock, registered.
- sr_latch  out  1  external latch strobe.
- busy  out  1  high from grant until frame end.
- frame_done  out  1  one-cycle pulse at frame end.
- blink  in  1  (macro only) blank the granted source's segments during the off phase.

## Operation
- States: IDLE, LOAD, SHIFT, LATCH.
- IDLE: when en and (req_a or req_b): arbiter picks winner; next edge sets gnt_x, busy, digit_sel=NUM_DIGITS-1, state LOAD.
- Arbitration: single request wins. On a tie, the source not granted most recently wins. Last-granted resets to B, so A wins the first tie.
- Requests are sampled only in IDLE. Deasserting a request mid-frame does not shorten the frame.
- LOAD: shift register captures the granted source's seg_x at the end of the cycle.
- SHIFT: 2*SEG_BITS cycles per digit.
  - Even phase: sr_data = sreg MSB, sr_clk=0.
  - Odd phase: sr_clk=1, sr_data unchanged; sreg shifts left at the end of the phase.
  - After the last bit: if digit_sel==0, go to LATCH; otherwise digit_sel decrements and state returns to LOAD.
- LATCH: sr_latch=1, sr_clk=0 for one cycle.
  - frame_done pulses in this same cycle.
  - Next edge: grant and busy drop; last-granted is updated; state returns to IDLE.
- A request still asserted in IDLE is re-arbitrated immediately. There is no dead cycle beyond the single IDLE cycle.
- en low in any state: hold state, counters, shift register and every output (sr_clk stays at its current level). frame_done extends only if en drops during LATCH.

## Timing
- Reset (async): state IDLE, gnt_a=gnt_b=0, busy=0, digit_sel=0, sr_data=0, sr_clk=0, sr_latch=0, frame_done=0, last-granted=B, blink phase=on.
- Reset mid-frame aborts immediately. No latch pulse is issued.
- Grant latency: 1 cycle from a request seen in IDLE.
- Frame length (grant high, en=1): NUM_DIGITS*(1+2*SEG_BITS)+1 cycles. This is 103 at the defaults.
- Back-to-back frame period: that length + 1 (IDLE) = 104 cycles.
- Setup and hold: sr_data is stable one cycle before and during each sr_clk high cycle.
- First bit shifted is digit NUM_DIGITS-1, bit SEG_BITS-1. The last bit is digit 0, bit 0.
- digit_sel is stable for the whole LOAD and SHIFT span of its digit. Sources present seg_x combinationally or registered on digit_sel with 0-cycle read latency.

## Configuration
- DISPLAY_BLINK_EN defined:
  - Adds the blink port and a frame counter mod BLINK_FRAMES that toggles the blink phase on each wrap.
  - In LOAD, when blink=1 and the phase is off, zero is captured instead of seg_x.
  - The counter advances on every frame_done, whichever source is granted.
- DISPLAY_BLINK_EN undefined: no port, no counter; seg_x is always captured.

## Structure
- Package display_pkg:
  - State enum.
  - Default NUM_DIGITS and SEG_BITS constants.
  - Source-ID constants SRC_A and SRC_B.
- Sub-module rr_arbiter2: two-requester round-robin arbiter.
  - Inputs: req_a, req_b, last-granted.
  - Output: one-hot winner, combinational.
  - The scheduler owns the last-granted register.

## Test plan
- Single source: req_a=1 only, seg_a = 0x80|digit → gnt_a after 1 cycle, 6 bytes shifted digit 5→0 MSB first, sr_latch and frame_done at cycle 103, gnt_a drops at 104.
- Tie: req_a=req_b=1 held → frames alternate A, B, A, B. The first frame goes to A, and no frame is granted to both.
- Request drop: req_b deasserted 10 cycles into a B frame → the frame still completes all 103 cycles.
- en gating: en=0 for 7 cycles mid-SHIFT with sr_clk=1 → outputs frozen (sr_clk held high), frame ends 7 cycles late, bit stream identical.
- Async reset at cycle 50 of a frame → all outputs 0 at once, no sr_latch. A new frame starts 1 cycle after rst_n rises if a request is held.
- DISPLAY_BLINK_EN, blink=1, BLINK_FRAMES=2 → frames 0–1 show data, frames 2–3 shift all zeros, repeating.
